// File: rtl/and_unit_arbiter.sv
// and_unit_arbiter: round-robin arbiter sharing one registered W-bit AND unit among N requesters
// Define AND_ARB_OPSEL_EN to add per-requester opcodes (AND/OR/XOR/NAND) on req_op.
module and_unit_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
`ifdef AND_ARB_OPSEL_EN
  input  logic [N*2-1:0] req_op,
`endif
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_c,
  output logic [15:0]    txn_cnt
);
  typedef enum logic {IDLE, FULL} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, g, idx, id_q;
  logic [IDW:0] s;
  logic [W-1:0] a, b, res, c_q;
  logic [15:0] cnt_q;
  logic found, gnt_en, gnt;
  always_comb begin
    found = 1'b0;
    g = '0;
    s = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, rr_q} + (IDW+1)'(k);
      s = (s >= (IDW+1)'(N)) ? s - (IDW+1)'(N) : s;
      idx = s[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  assign gnt_en = ~rst & ((state_q == IDLE) | rsp_ready);
  assign gnt = gnt_en & found;
  assign req_ready = gnt ? {{(N-1){1'b0}}, 1'b1} << g : '0;
  assign a = req_a[g*W +: W];
  assign b = req_b[g*W +: W];
`ifdef AND_ARB_OPSEL_EN
  logic [1:0] op;
  assign op = req_op[g*2 +: 2];
  assign res = (op == 2'b00) ? a & b : (op == 2'b01) ? a | b : (op == 2'b10) ? a ^ b : ~(a & b);
`else
  assign res = a & b;
`endif
  always_comb begin
    rr_d = gnt ? ((g == IDW'(N-1)) ? '0 : g + 1'b1) : rr_q;
    state_d = gnt ? FULL : (state_q == FULL && rsp_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      c_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      if (gnt) begin
        id_q <= g;
        c_q <= res;
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end
  assign rsp_valid = (state_q == FULL);
  assign rsp_id = id_q;
  assign rsp_c = c_q;
  assign txn_cnt = cnt_q;
endmodule

// File: tb/tb_and_unit_arbiter.sv
// tb_and_unit_arbiter: directed + random bench with reference model and response scoreboard
module tb_and_unit_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 0, rst = 1, rsp_ready = 1;
  logic [N-1:0] req_valid = '1, req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N*2-1:0] req_op = '0;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_c, held;
  logic [15:0] txn_cnt;
  int n_cmp = 0, n_err = 0;
  bit started = 0;

  and_unit_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef AND_ARB_OPSEL_EN
    .req_op(req_op),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
`ifdef AND_ARB_OPSEL_EN
    case (o)
      2'b00: return x & y;
      2'b01: return x | y;
      2'b10: return x ^ y;
      default: return ~(x & y);
    endcase
`else
    return x & y;
`endif
  endfunction

  logic [15:0] sb[$];
  int rr_m = 0;
  bit full_m = 0;
  logic [15:0] cnt_m = 0;

  always @(negedge clk) begin
    if (started) begin
      int gi;
      bit en;
      logic [N-1:0] exp_rdy;
      logic [15:0] ent;
      en = !rst && (!full_m || rsp_ready);
      gi = -1;
      for (int k = 0; k < N; k++)
        if (gi < 0 && req_valid[(rr_m + k) % N]) gi = (rr_m + k) % N;
      exp_rdy = (en && gi >= 0) ? N'(1) << gi : '0;
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, full_m);
      chk("txn_cnt", txn_cnt, cnt_m);
      if (full_m) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          ent = sb[0];
          chk("rsp_id", rsp_id, ent[15:8]);
          chk("rsp_c", rsp_c, ent[7:0]);
        end
      end
      if (rst) begin
        sb.delete();
        full_m = 0;
        rr_m = 0;
        cnt_m = 0;
      end else begin
        if (full_m && rsp_ready && sb.size() > 0) void'(sb.pop_front());
        if (en && gi >= 0) begin
          ent = {8'(gi), calc(req_a[gi*W +: W], req_b[gi*W +: W], req_op[gi*2 +: 2])};
          sb.push_back(ent);
          full_m = 1;
          rr_m = (gi + 1) % N;
          cnt_m = cnt_m + 16'd1;
        end else if (full_m && rsp_ready) full_m = 0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1 started = 1;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_c", rsp_c, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_cnt", txn_cnt, 0);
    step();
    rst = 0;
    req_valid = '0;
    step();
    req_valid = 4'b0100;
    req_a[2*W +: W] = 8'hF0;
    req_b[2*W +: W] = 8'h3C;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    chk("single_c", rsp_c, 8'h30);
    rst = 1;
    step();
    rst = 0;
    req_valid = 4'hF;
    req_a = 32'h1234_5678;
    req_b = 32'hF0F0_0F0F;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("fair_grant", req_ready, 4'b0001 << (k % 4));
      step();
    end
    rsp_ready = 0;
    @(negedge clk);
    chk("fair_cnt", txn_cnt, 5);
    held = rsp_c;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_c", rsp_c, held);
      step();
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_release", req_ready, 4'b0010);
    step();
    req_valid = 4'h3;
    rst = 1;
    @(negedge clk);
    chk("mid_valid_before", rsp_valid, 1);
    step();
    rst = 0;
    @(negedge clk);
    chk("mid_valid_after", rsp_valid, 0);
    chk("mid_first", req_ready, 4'b0001);
    step();
`ifdef AND_ARB_OPSEL_EN
    req_valid = 4'b0010;
    req_op[2*1 +: 2] = 2'b10;
    req_a[1*W +: W] = 8'hAA;
    req_b[1*W +: W] = 8'hFF;
    step();
    req_op[2*1 +: 2] = 2'b11;
    req_a[1*W +: W] = 8'hFF;
    @(negedge clk);
    chk("op_xor_c", rsp_c, 8'h55);
    chk("op_xor_id", rsp_id, 1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("op_nand_c", rsp_c, 8'h00);
    step();
`endif
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      req_a = $urandom;
      req_b = $urandom;
      req_op = 8'($urandom);
      rst = ($urandom % 60) == 0;
      step();
    end
    rst = 0;
    req_valid = '0;
    rsp_ready = 1;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
